serial_word_adder: RTL and testbench
====================================

# serial_word_adder

Parametrised multi-cycle adder/subtractor that computes a WIDTH-bit `a + b + cin` or `a - b - cin` one DIGIT-bit slice per clock. A carry register links the slices, so each cycle uses a DIGIT-wide ripple of full-adder cells. It is the sequential, width-generic successor to the team's single-bit full adder. It sits between a producer and a consumer on valid/ready handshakes, and is used where area matters more than throughput.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be a multiple of DIGIT.
- `DIGIT`, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT cycles per operation.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands and mode are valid.
- `in_ready`  output  1  block can accept an operation (high only in IDLE).
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in for add, or borrow-in for subtract.
- `sub`  input  1  0 = add, 1 = subtract.
- `out_valid`  output  1  result is valid.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  WIDTH  result.
- `cout`  output  1  final carry-out. For subtract, 1 means no borrow.
- `ovf`  output  1  two's-complement signed overflow.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN when `in_valid && in_ready`.
  - RUN → DONE after N slice cycles.
  - DONE → IDLE when `out_ready`.
- **Accept:** register `a`, the effective operand `b_eff`, and the initial carry.
  - Add: `b_eff = b`, initial carry = `cin`.
  - Subtract: `b_eff = ~b`, initial carry = `~cin`. This gives `a + ~b + ~cin = a - b - cin` mod 2^WIDTH.
- Clear the slice index and the result register on accept.
- **Each RUN cycle (slice index k = 0..N-1, LSB slice first):**
  - Compute `{c, s} = a[k] + b_eff[k] + carry`, using DIGIT-bit slices.
  - Write `s` into result bits `[k*DIGIT +: DIGIT]`.
  - Set `carry <= c`.
  - Shift-register or indexed implementations are both acceptable; the observable behaviour must be identical.
- **On the last slice:**
  - `cout` = final carry.
  - `ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])`.
- **Width rule:** `sum` is exact mod 2^WIDTH. No saturation.
- Operands are captured at accept, so input changes after accept have no effect.
- `in_valid` while busy (RUN or DONE) is ignored. The block never queues a second operation.
- **Reset:**
  - State → IDLE.
  - `out_valid = 0`, `sum = 0`, `cout = 0`, `ovf = 0`.
  - Carry, slice index and operand registers cleared.
  - `in_ready = 1` from the first cycle after `rst` deasserts.
  - `in_ready` is low while `rst` is high.
- **Reset mid-operation** (RUN or DONE): the operation is discarded, `out_valid` never rises for it, and it is not resumed.

## Timing
- Accept edge is E0. Slices are computed on edges E1..EN.
- `out_valid` rises after EN, i.e. latency is N cycles from accept to `out_valid`.
- `sum`, `cout` and `ovf` are registered. They change only at the edge that sets `out_valid`, and then hold stable while `out_valid && !out_ready`.
- Result handoff occurs on the edge where `out_valid && out_ready`.
  - On that edge `out_valid` falls and `in_ready` rises.
  - `sum`, `cout` and `ovf` keep their last values until the next result is written.
- Minimum issue interval is N+2 cycles: accept, N RUN cycles, then 1 DONE cycle with `out_ready` high.
- The DIGIT = WIDTH case (N = 1) must work: latency 1.
- `in_ready` and `out_valid` are decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
Bench parameters: WIDTH = 8, DIGIT = 2 (N = 4) unless stated otherwise.
- **Add:** `a=0x3C`, `b=0x0F`, `cin=0`, `sub=0` → `sum=0x4B`, `cout=0`, `ovf=0`. `out_valid` rises exactly 4 cycles after the accept edge.
- **Add carry and overflow:**
  - `0xFF + 0x01` → `sum=0x00`, `cout=1`, `ovf=0`.
  - `0x7F + 0x01` → `sum=0x80`, `cout=0`, `ovf=1`.
  - `0x00 + 0x00`, `cin=1` → `sum=0x01`.
- **Subtract:**
  - `0x05 - 0x07`, `cin=0` → `sum=0xFE`, `cout=0` (borrow), `ovf=0`.
  - `0x80 - 0x01` → `sum=0x7F`, `cout=1`, `ovf=1`.
  - `0x10 - 0x00`, `cin=1` → `sum=0x0F`, `cout=1`.
- **Backpressure:**
  - Hold `out_ready=0` for 3 cycles after `out_valid`: `sum`, `cout` and `ovf` stay stable and `in_ready=0`.
  - Pulse `in_valid` with new operands during that window: no effect.
  - Raise `out_ready`: next cycle `in_ready=1`.
- **Reset mid-run:**
  - Assert `rst` on the 2nd RUN cycle: `out_valid` stays 0, all outputs read 0, and `in_ready=1` the cycle after release.
  - Then issue `0x12 + 0x34` → `sum=0x46`.
- **Random regression:** 1000 random operations with random `sub`, `cin`, and `in_valid`/`out_ready` gaps, for both (WIDTH=8, DIGIT=8) and (WIDTH=32, DIGIT=4), each compared against a behavioural model.

Source files
------------

// File: rtl/serial_word_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice per clock, LSB slice first,
// with a carry register linking slices and valid/ready handshakes on both sides.

module swa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_word_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // captured operation; b already holds the effective (possibly inverted) operand
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] res, res_nxt;
  logic [DIGIT-1:0] sa, sb, ss;
  logic [DIGIT:0]   cc;
  logic             last;

  assign sa    = op_q.a[int'(idx)*DIGIT +: DIGIT];
  assign sb    = op_q.b[int'(idx)*DIGIT +: DIGIT];
  assign cc[0] = carry;
  assign last  = (idx == IW'(N-1));

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    swa_fa_cell u_fa (.a(sa[i]), .b(sb[i]), .ci(cc[i]), .s(ss[i]), .co(cc[i+1]));
  end

  always_comb begin
    res_nxt = res;
    res_nxt[int'(idx)*DIGIT +: DIGIT] = ss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      op_q      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q.a   <= a;
            op_q.b   <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            idx      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= cc[DIGIT];
          idx   <= idx + 1'b1;
          if (last) begin
            sum       <= res_nxt;
            cout      <= cc[DIGIT];
            ovf       <= (op_q.a[WIDTH-1] == op_q.b[WIDTH-1]) &&
                         (res_nxt[WIDTH-1] != op_q.a[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: directed cases on an (8,2) instance, random regression on
// (8,8) and (32,4) instances against a signed/unsigned arithmetic model.

module tb_serial_word_adder;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  ivs, ors, ir, rv, co_v, of_v;
  logic [31:0] a32, b32;
  logic        cin, op;
  logic [7:0]  sum0, sum1;
  logic [31:0] sum2;
  logic [31:0] sm [3];
  int          passed = 0;
  int          total  = 0;

  always_comb begin
    sm[0] = {24'h0, sum0};
    sm[1] = {24'h0, sum1};
    sm[2] = sum2;
  end

  serial_word_adder #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(ivs[0]), .in_ready(ir[0]), .a(a32[7:0]), .b(b32[7:0]),
    .cin(cin), .sub(op), .out_valid(rv[0]), .out_ready(ors[0]), .sum(sum0), .cout(co_v[0]),
    .ovf(of_v[0]));
  serial_word_adder #(.WIDTH(8), .DIGIT(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(ivs[1]), .in_ready(ir[1]), .a(a32[7:0]), .b(b32[7:0]),
    .cin(cin), .sub(op), .out_valid(rv[1]), .out_ready(ors[1]), .sum(sum1), .cout(co_v[1]),
    .ovf(of_v[1]));
  serial_word_adder #(.WIDTH(32), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(ivs[2]), .in_ready(ir[2]), .a(a32), .b(b32),
    .cin(cin), .sub(op), .out_valid(rv[2]), .out_ready(ors[2]), .sum(sum2), .cout(co_v[2]),
    .ovf(of_v[2]));

  // reference: exact integer arithmetic, then wrap / range-test
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic ci, input logic sb, output logic [31:0] s,
                                output logic co, output logic ov);
    longint m, ua, ub, sa, sbv, r, sr, c;
    m   = longint'(1) << w;
    ua  = longint'(a) & (m - 1);
    ub  = longint'(b) & (m - 1);
    c   = longint'(ci);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    r   = sb ? ua - ub - c : ua + ub + c;
    sr  = sb ? sa - sbv - c : sa + sbv + c;
    s   = 32'(r & (m - 1));
    co  = sb ? (r >= 0) : (r >= m);
    ov  = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  // drive one operation through instance sel; lat = -1 on any timeout
  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic o, input int hold, output int lat,
                       output logic [31:0] s, output logic co, output logic ov);
    int w = 0;
    lat = -1; s = '0; co = 1'b0; ov = 1'b0;
    while (!ir[sel] && w < 20) begin @(negedge clk); w++; end
    if (!ir[sel]) return;
    a32 = a; b32 = b; cin = ci; op = o; ivs[sel] = 1'b1;
    @(negedge clk);
    ivs[sel] = 1'b0;
    a32 = $urandom; b32 = $urandom; cin = 1'($urandom); op = 1'($urandom);
    lat = 0;
    while (!rv[sel] && lat < 100) begin @(negedge clk); lat++; end
    if (!rv[sel]) begin lat = -1; return; end
    repeat (hold) @(negedge clk);
    s = sm[sel]; co = co_v[sel]; ov = of_v[sel];
    ors[sel] = 1'b1;
    @(negedge clk);
    ors[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ir, rv} !== 6'b0) $display("FAIL reset_hs: ir=%b rv=%b want 000/000", ir, rv);
    else passed++;
    total++;
    if ({sum0, co_v[0], of_v[0]} !== 10'h0)
      $display("FAIL reset_out: sum=%h co=%b ov=%b want 0", sum0, co_v[0], of_v[0]);
    else passed++;
    total++;
    if (sum2 !== 32'h0) $display("FAIL reset_sum32: got %h want 0", sum2);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ir !== 3'b111 || rv !== 3'b000)
      $display("FAIL reset_release: ir=%b rv=%b want 111/000", ir, rv);
    else passed++;
  endtask

  task automatic test_add();
    int lat; logic [31:0] s; logic co, ov;
    issue(0, 32'h3C, 32'h0F, 1'b0, 1'b0, 0, lat, s, co, ov);
    total++;
    if (lat !== 4) $display("FAIL add_latency: got %0d want 4", lat);
    else passed++;
    total++;
    if ({s[7:0], co, ov} !== {8'h4B, 1'b0, 1'b0})
      $display("FAIL add_result: sum=%h co=%b ov=%b want 4b/0/0", s[7:0], co, ov);
    else passed++;
    total++;
    if (ir[0] !== 1'b1 || rv[0] !== 1'b0)
      $display("FAIL add_handoff: ir=%b rv=%b want 1/0", ir[0], rv[0]);
    else passed++;
  endtask

  task automatic test_add_carry();
    logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h00};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] te [3] = '{{8'h00, 2'b10}, {8'h80, 2'b01}, {8'h01, 2'b00}};
    int lat; logic [31:0] s; logic co, ov;
    for (int i = 0; i < 3; i++) begin
      issue(0, {24'h0, ta[i]}, {24'h0, tb[i]}, tc[i], 1'b0, 0, lat, s, co, ov);
      total++;
      if (lat !== 4 || {s[7:0], co, ov} !== te[i])
        $display("FAIL add_carry%0d: lat=%0d {sum,co,ov}=%h want lat 4 %h", i, lat,
                 {s[7:0], co, ov}, te[i]);
      else passed++;
    end
  endtask

  task automatic test_sub();
    logic [7:0] ta [3] = '{8'h05, 8'h80, 8'h10};
    logic [7:0] tb [3] = '{8'h07, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] te [3] = '{{8'hFE, 2'b00}, {8'h7F, 2'b11}, {8'h0F, 2'b10}};
    int lat; logic [31:0] s; logic co, ov;
    for (int i = 0; i < 3; i++) begin
      issue(0, {24'h0, ta[i]}, {24'h0, tb[i]}, tc[i], 1'b1, 1, lat, s, co, ov);
      total++;
      if (lat !== 4 || {s[7:0], co, ov} !== te[i])
        $display("FAIL sub%0d: lat=%0d {sum,co,ov}=%h want lat 4 %h", i, lat,
                 {s[7:0], co, ov}, te[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int lat = 0; int w = 0; logic stray = 1'b0;
    while (!ir[0] && w < 20) begin @(negedge clk); w++; end
    a32 = 32'h11; b32 = 32'h22; cin = 1'b0; op = 1'b0; ivs[0] = 1'b1;
    @(negedge clk);
    ivs[0] = 1'b0;
    while (!rv[0] && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4) $display("FAIL bp_latency: got %0d want 4", lat);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({rv[0], ir[0], sum0, co_v[0], of_v[0]} !== {2'b10, 8'h33, 2'b00})
        $display("FAIL bp_hold%0d: rv=%b ir=%b sum=%h co=%b ov=%b want 1/0/33/0/0", k,
                 rv[0], ir[0], sum0, co_v[0], of_v[0]);
      else passed++;
      ivs[0] = (k == 1);
      a32 = 32'hAA; b32 = 32'h55; op = 1'b1; cin = 1'b1;
      @(negedge clk);
    end
    ivs[0] = 1'b0;
    ors[0] = 1'b1;
    @(negedge clk);
    ors[0] = 1'b0;
    total++;
    if ({ir[0], rv[0], sum0} !== {2'b10, 8'h33})
      $display("FAIL bp_release: ir=%b rv=%b sum=%h want 1/0/33", ir[0], rv[0], sum0);
    else passed++;
    repeat (6) begin @(negedge clk); if (rv[0]) stray = 1'b1; end
    total++;
    if (stray !== 1'b0) $display("FAIL bp_no_queue: out_valid rose=%b want 0", stray);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [31:0] s; logic co, ov;
    a32 = 32'hAA; b32 = 32'h11; cin = 1'b0; op = 1'b0; ivs[0] = 1'b1;
    @(negedge clk);
    ivs[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({rv[0], ir[0], sum0, co_v[0], of_v[0]} !== 12'h0)
      $display("FAIL midrst_out: rv=%b ir=%b sum=%h co=%b ov=%b want all 0", rv[0], ir[0],
               sum0, co_v[0], of_v[0]);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ir[0] !== 1'b1 || rv[0] !== 1'b0)
      $display("FAIL midrst_release: ir=%b rv=%b want 1/0", ir[0], rv[0]);
    else passed++;
    issue(0, 32'h12, 32'h34, 1'b0, 1'b0, 0, lat, s, co, ov);
    total++;
    if (lat !== 4 || {s[7:0], co, ov} !== {8'h46, 2'b00})
      $display("FAIL midrst_next: lat=%0d sum=%h co=%b ov=%b want 4/46/0/0", lat, s[7:0],
               co, ov);
    else passed++;
  endtask

  task automatic test_random(input int sel, input int w, input int nlat, input int n);
    int lat; logic [31:0] ra, rb, s, es; logic rc, ro, co, ov, eco, eov;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = $urandom; rb = $urandom; rc = 1'($urandom); ro = 1'($urandom);
      model(w, ra, rb, rc, ro, es, eco, eov);
      issue(sel, ra, rb, rc, ro, $urandom_range(0, 3), lat, s, co, ov);
      total++;
      if (lat !== nlat) $display("FAIL rand%0d_lat[%0d]: got %0d want %0d", sel, i, lat, nlat);
      else passed++;
      total++;
      if ({s, co, ov} !== {es, eco, eov})
        $display("FAIL rand%0d_res[%0d]: a=%h b=%h cin=%b sub=%b got %h/%b/%b want %h/%b/%b",
                 sel, i, ra, rb, rc, ro, s, co, ov, es, eco, eov);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; ivs = '0; ors = '0; a32 = '0; b32 = '0; cin = 1'b0; op = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_add_carry();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_random(1, 8, 1, 1000);
    test_random(2, 32, 8, 1000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed,
             total);
    $fatal(1);
  end
endmodule
